// File: rtl/echo_app_rx_msg_if_ctrl_pkg.sv
// Shared types for the echo app receive message interface.
// Holds the buffer mux selector, the control FSM state encoding and the counter width.
package echo_app_rx_msg_if_ctrl_pkg;

    localparam int MSGS_DONE_W = 32;

    typedef enum logic [1:0] {
        HDR_VALUES     = 2'd0,
        PAYLOAD_VALUES = 2'd1,
        PTR_UPDATE     = 2'd2
    } buf_mux_sel_e;

    typedef enum logic [3:0] {
        READ_ACTIVE  = 4'd0,
        HDR_REQ      = 4'd1,
        HDR_NOTIF    = 4'd2,
        HDR_BUF_REQ  = 4'd3,
        HDR_BUF_RESP = 4'd4,
        PL_REQ       = 4'd5,
        PL_NOTIF     = 4'd6,
        TX_MSG       = 4'd7,
        TX_WAIT      = 4'd8,
        PTR_UPD      = 4'd9,
        REQUEUE      = 4'd10
    } rx_msg_if_state_e;

endpackage

// File: rtl/echo_app_rx_msg_if_ctrl.sv
// Receive-side message control for the echo app: pops a flow, fetches its header,
// hands the payload to TX, advances the RX head pointer and requeues the flow.
module echo_app_rx_msg_if_ctrl
    import echo_app_rx_msg_if_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   active_q_msg_if_empty,
    output logic                   msg_if_active_q_rd_req,
    input  logic                   active_q_msg_if_full,
    output logic                   msg_if_active_q_wr_req,

    output logic                   rx_app_noc_vrtoc_val,
    input  logic                   noc_vrtoc_rx_app_rdy,
    input  logic                   noc_ctovr_rx_app_val,
    output logic                   rx_app_noc_ctovr_rdy,

    output logic                   datap_rd_buf_req_val,
    input  logic                   rd_buf_datap_req_rdy,
    input  logic                   rd_buf_datap_resp_data_val,
    output logic                   datap_rd_buf_resp_data_rdy,
    input  logic                   rd_buf_datap_resp_data_last,

    output logic                   rx_if_tx_if_msg_val,
    input  logic                   tx_if_rx_if_msg_rdy,
    input  logic                   tx_if_rx_if_msg_done,

    output logic                   ctrl_datap_store_flowid,
    output logic                   ctrl_datap_store_hdr,
    output logic                   ctrl_datap_store_notif,
    output buf_mux_sel_e           ctrl_datap_buf_mux_sel,
    input  logic                   datap_ctrl_last_req,

    output logic [MSGS_DONE_W-1:0] ctrl_msgs_done
);

    rx_msg_if_state_e state;
    rx_msg_if_state_e state_next;
    logic             first_beat;
    logic             msg_retired;

    // A flow marked last is dropped immediately; otherwise retirement waits for queue space.
    assign msg_retired = (state == REQUEUE) && (datap_ctrl_last_req || !active_q_msg_if_full);

    // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= READ_ACTIVE;
            ctrl_msgs_done <= '0;
            first_beat     <= 1'b1;
        end else begin
            state <= state_next;
            if (msg_retired) begin
                ctrl_msgs_done <= ctrl_msgs_done + MSGS_DONE_W'(1);
            end
            // Response ready is always high in HDR_BUF_RESP, so a valid beat is a transfer.
            if ((state == HDR_BUF_RESP) && rd_buf_datap_resp_data_val) begin
                first_beat <= rd_buf_datap_resp_data_last;
            end
        end
    end

    // NOTE: every combinational process assigns defaults first so no latches are inferred.
    always_comb begin
        state_next = state;
        case (state)
            READ_ACTIVE:  if (!active_q_msg_if_empty)       state_next = HDR_REQ;
            HDR_REQ:      if (noc_vrtoc_rx_app_rdy)         state_next = HDR_NOTIF;
            HDR_NOTIF:    if (noc_ctovr_rx_app_val)         state_next = HDR_BUF_REQ;
            HDR_BUF_REQ:  if (rd_buf_datap_req_rdy)         state_next = HDR_BUF_RESP;
            HDR_BUF_RESP: if (rd_buf_datap_resp_data_val && rd_buf_datap_resp_data_last)
                                                            state_next = PL_REQ;
            PL_REQ:       if (noc_vrtoc_rx_app_rdy)         state_next = PL_NOTIF;
            PL_NOTIF:     if (noc_ctovr_rx_app_val)         state_next = TX_MSG;
            TX_MSG:       if (tx_if_rx_if_msg_rdy)          state_next = TX_WAIT;
            TX_WAIT:      if (tx_if_rx_if_msg_done)         state_next = PTR_UPD;
            PTR_UPD:      if (noc_vrtoc_rx_app_rdy)         state_next = REQUEUE;
            REQUEUE:      if (msg_retired)                  state_next = READ_ACTIVE;
            default:                                        state_next = READ_ACTIVE;
        endcase
    end

    // Valids depend only on state; stores qualify on the peer's valid, never on our own ready.
    always_comb begin
        msg_if_active_q_rd_req     = 1'b0;
        msg_if_active_q_wr_req     = 1'b0;
        rx_app_noc_vrtoc_val       = 1'b0;
        rx_app_noc_ctovr_rdy       = 1'b0;
        datap_rd_buf_req_val       = 1'b0;
        datap_rd_buf_resp_data_rdy = 1'b0;
        rx_if_tx_if_msg_val        = 1'b0;
        ctrl_datap_store_flowid    = 1'b0;
        ctrl_datap_store_hdr       = 1'b0;
        ctrl_datap_store_notif     = 1'b0;
        ctrl_datap_buf_mux_sel     = PAYLOAD_VALUES;
        case (state)
            READ_ACTIVE: begin
                msg_if_active_q_rd_req  = !active_q_msg_if_empty;
                ctrl_datap_store_flowid = !active_q_msg_if_empty;
            end
            HDR_REQ: begin
                rx_app_noc_vrtoc_val   = 1'b1;
                ctrl_datap_buf_mux_sel = HDR_VALUES;
            end
            HDR_NOTIF: begin
                rx_app_noc_ctovr_rdy   = 1'b1;
                ctrl_datap_store_notif = noc_ctovr_rx_app_val;
                ctrl_datap_buf_mux_sel = HDR_VALUES;
            end
            HDR_BUF_REQ: begin
                datap_rd_buf_req_val   = 1'b1;
                ctrl_datap_buf_mux_sel = HDR_VALUES;
            end
            HDR_BUF_RESP: begin
                datap_rd_buf_resp_data_rdy = 1'b1;
                ctrl_datap_store_hdr       = rd_buf_datap_resp_data_val && first_beat;
                ctrl_datap_buf_mux_sel     = HDR_VALUES;
            end
            PL_REQ: begin
                rx_app_noc_vrtoc_val = 1'b1;
            end
            PL_NOTIF: begin
                rx_app_noc_ctovr_rdy   = 1'b1;
                ctrl_datap_store_notif = noc_ctovr_rx_app_val;
            end
            TX_MSG: begin
                rx_if_tx_if_msg_val = 1'b1;
            end
            PTR_UPD: begin
                rx_app_noc_vrtoc_val   = 1'b1;
                ctrl_datap_buf_mux_sel = PTR_UPDATE;
            end
            REQUEUE: begin
                msg_if_active_q_wr_req = !datap_ctrl_last_req && !active_q_msg_if_full;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_echo_app_rx_msg_if_ctrl.sv
// Directed bench for echo_app_rx_msg_if_ctrl: walks whole messages and checks every
// control output each cycle against hand-written per-state vectors.
module tb_echo_app_rx_msg_if_ctrl;
    import echo_app_rx_msg_if_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        active_q_msg_if_empty = 1'b1;
    logic        msg_if_active_q_rd_req;
    logic        active_q_msg_if_full = 1'b0;
    logic        msg_if_active_q_wr_req;
    logic        rx_app_noc_vrtoc_val;
    logic        noc_vrtoc_rx_app_rdy = 1'b1;
    logic        noc_ctovr_rx_app_val = 1'b1;
    logic        rx_app_noc_ctovr_rdy;
    logic        datap_rd_buf_req_val;
    logic        rd_buf_datap_req_rdy = 1'b1;
    logic        rd_buf_datap_resp_data_val = 1'b1;
    logic        datap_rd_buf_resp_data_rdy;
    logic        rd_buf_datap_resp_data_last = 1'b1;
    logic        rx_if_tx_if_msg_val;
    logic        tx_if_rx_if_msg_rdy = 1'b1;
    logic        tx_if_rx_if_msg_done = 1'b0;
    logic        ctrl_datap_store_flowid;
    logic        ctrl_datap_store_hdr;
    logic        ctrl_datap_store_notif;
    buf_mux_sel_e ctrl_datap_buf_mux_sel;
    logic        datap_ctrl_last_req = 1'b0;
    logic [31:0] ctrl_msgs_done;

    echo_app_rx_msg_if_ctrl dut (
        .clk                         (clk),
        .rst                         (rst),
        .active_q_msg_if_empty       (active_q_msg_if_empty),
        .msg_if_active_q_rd_req      (msg_if_active_q_rd_req),
        .active_q_msg_if_full        (active_q_msg_if_full),
        .msg_if_active_q_wr_req      (msg_if_active_q_wr_req),
        .rx_app_noc_vrtoc_val        (rx_app_noc_vrtoc_val),
        .noc_vrtoc_rx_app_rdy        (noc_vrtoc_rx_app_rdy),
        .noc_ctovr_rx_app_val        (noc_ctovr_rx_app_val),
        .rx_app_noc_ctovr_rdy        (rx_app_noc_ctovr_rdy),
        .datap_rd_buf_req_val        (datap_rd_buf_req_val),
        .rd_buf_datap_req_rdy        (rd_buf_datap_req_rdy),
        .rd_buf_datap_resp_data_val  (rd_buf_datap_resp_data_val),
        .datap_rd_buf_resp_data_rdy  (datap_rd_buf_resp_data_rdy),
        .rd_buf_datap_resp_data_last (rd_buf_datap_resp_data_last),
        .rx_if_tx_if_msg_val         (rx_if_tx_if_msg_val),
        .tx_if_rx_if_msg_rdy         (tx_if_rx_if_msg_rdy),
        .tx_if_rx_if_msg_done        (tx_if_rx_if_msg_done),
        .ctrl_datap_store_flowid     (ctrl_datap_store_flowid),
        .ctrl_datap_store_hdr        (ctrl_datap_store_hdr),
        .ctrl_datap_store_notif      (ctrl_datap_store_notif),
        .ctrl_datap_buf_mux_sel      (ctrl_datap_buf_mux_sel),
        .datap_ctrl_last_req         (datap_ctrl_last_req),
        .ctrl_msgs_done              (ctrl_msgs_done)
    );

    always #5 clk = ~clk;

    // Flag order: rd_req wr_req vrtoc_val ctovr_rdy buf_req_val resp_rdy msg_val st_flowid st_hdr st_notif
    localparam logic [9:0] F_NONE  = 10'b0000000000;
    localparam logic [9:0] F_POP   = 10'b1000000100;
    localparam logic [9:0] F_WR    = 10'b0100000000;
    localparam logic [9:0] F_VR    = 10'b0010000000;
    localparam logic [9:0] F_CT_SN = 10'b0001000001;
    localparam logic [9:0] F_BQ    = 10'b0000100000;
    localparam logic [9:0] F_RR_SH = 10'b0000010010;
    localparam logic [9:0] F_RR    = 10'b0000010000;
    localparam logic [9:0] F_MV    = 10'b0000001000;

    logic [11:0] obs_vec;
    assign obs_vec = {msg_if_active_q_rd_req, msg_if_active_q_wr_req, rx_app_noc_vrtoc_val,
                      rx_app_noc_ctovr_rdy, datap_rd_buf_req_val, datap_rd_buf_resp_data_rdy,
                      rx_if_tx_if_msg_val, ctrl_datap_store_flowid, ctrl_datap_store_hdr,
                      ctrl_datap_store_notif, ctrl_datap_buf_mux_sel};

    int n_pass  = 0;
    int n_total = 0;
    int n_flits = 0;
    int n_wr    = 0;
    int n_hdr   = 0;
    int exp_flits = 0;
    int exp_wr    = 0;
    int exp_hdr   = 0;
    logic [31:0] exp_done = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (rx_app_noc_vrtoc_val && noc_vrtoc_rx_app_rdy) n_flits++;
            if (msg_if_active_q_wr_req) n_wr++;
            if (ctrl_datap_store_hdr) n_hdr++;
        end
    end

    function automatic logic [11:0] ev(input logic [9:0] f, input buf_mux_sel_e m);
        return {f, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [11:0] exp);
        #1 check(tag, 32'(obs_vec), 32'(exp));
    endtask

    // One request state; rdy held low for bp cycles first, then exactly one flit.
    task automatic req_phase(input string tag, input int bp, input buf_mux_sel_e m);
        noc_vrtoc_rx_app_rdy = 1'b0;
        for (int i = 0; i < bp; i++) begin
            chk_vec({tag, "_hold"}, ev(F_VR, m));
            tick();
        end
        noc_vrtoc_rx_app_rdy = 1'b1;
        chk_vec(tag, ev(F_VR, m));
        exp_flits++;
        tick();
    endtask

    // Full message from READ_ACTIVE; abort=1 asserts rst while in TX_WAIT.
    task automatic walk(input string tag, input logic last, input int bp, input int beats,
                        input int full_cyc, input bit abort);
        tick();
        datap_ctrl_last_req  = last;
        active_q_msg_if_empty = 1'b0;
        chk_vec({tag, "_pop"}, ev(F_POP, PAYLOAD_VALUES));
        tick();
        active_q_msg_if_empty = 1'b1;
        req_phase({tag, "_hdr_req"}, bp, HDR_VALUES);
        chk_vec({tag, "_hdr_notif"}, ev(F_CT_SN, HDR_VALUES));
        tick();
        chk_vec({tag, "_hdr_buf_req"}, ev(F_BQ, HDR_VALUES));
        tick();
        for (int b = 1; b <= beats; b++) begin
            rd_buf_datap_resp_data_last = (b == beats);
            chk_vec({tag, "_hdr_resp"}, ev((b == 1) ? F_RR_SH : F_RR, HDR_VALUES));
            tick();
        end
        exp_hdr++;
        rd_buf_datap_resp_data_last = 1'b1;
        req_phase({tag, "_pl_req"}, bp, PAYLOAD_VALUES);
        chk_vec({tag, "_pl_notif"}, ev(F_CT_SN, PAYLOAD_VALUES));
        tick();
        chk_vec({tag, "_tx_msg"}, ev(F_MV, PAYLOAD_VALUES));
        tick();
        if (abort) begin
            rst = 1'b1;
            chk_vec({tag, "_tx_wait"}, ev(F_NONE, PAYLOAD_VALUES));
            tick();
            rst = 1'b0;
            exp_done = '0;
            return;
        end
        tx_if_rx_if_msg_done = 1'b1;
        chk_vec({tag, "_tx_wait"}, ev(F_NONE, PAYLOAD_VALUES));
        tick();
        tx_if_rx_if_msg_done = 1'b0;
        req_phase({tag, "_ptr_upd"}, bp, PTR_UPDATE);
        if (!last) begin
            active_q_msg_if_full = 1'b1;
            for (int i = 0; i < full_cyc; i++) begin
                chk_vec({tag, "_requeue_full"}, ev(F_NONE, PAYLOAD_VALUES));
                tick();
            end
            active_q_msg_if_full = 1'b0;
            chk_vec({tag, "_requeue_push"}, ev(F_WR, PAYLOAD_VALUES));
            exp_wr++;
        end else begin
            chk_vec({tag, "_requeue_drop"}, ev(F_NONE, PAYLOAD_VALUES));
        end
        exp_done++;
        tick();
        chk_vec({tag, "_idle"}, ev(F_NONE, PAYLOAD_VALUES));
        check({tag, "_msgs_done"}, ctrl_msgs_done, exp_done);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_vec("reset_outputs", ev(F_NONE, PAYLOAD_VALUES));
        check("reset_msgs_done", ctrl_msgs_done, 32'd0);

        walk("m1_last0",   1'b0, 0, 1, 0, 1'b0);
        walk("m2_last1",   1'b1, 0, 1, 0, 1'b0);
        walk("m3_backpr",  1'b0, 5, 1, 0, 1'b0);
        walk("m4_3beats",  1'b0, 0, 3, 0, 1'b0);
        walk("m5_qfull",   1'b0, 0, 1, 4, 1'b0);
        check("flit_count", 32'(n_flits), 32'(exp_flits));
        check("push_count", 32'(n_wr), 32'(exp_wr));
        check("store_hdr_count", 32'(n_hdr), 32'(exp_hdr));

        walk("m6_rst", 1'b0, 0, 1, 0, 1'b1);
        chk_vec("rst_outputs", ev(F_NONE, PAYLOAD_VALUES));
        check("rst_msgs_done", ctrl_msgs_done, exp_done);
        tx_if_rx_if_msg_done = 1'b1;
        tick();
        tx_if_rx_if_msg_done = 1'b0;
        chk_vec("late_done_ignored", ev(F_NONE, PAYLOAD_VALUES));
        tick();
        chk_vec("late_done_no_ptr", ev(F_NONE, PAYLOAD_VALUES));
        active_q_msg_if_empty = 1'b0;
        chk_vec("rst_then_pop", ev(F_POP, PAYLOAD_VALUES));
        check("rst_flit_count", 32'(n_flits), 32'(exp_flits));
        check("rst_push_count", 32'(n_wr), 32'(exp_wr));
        tick();
        active_q_msg_if_empty = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/echo_app_rx_msg_if_ctrl.md
# echo_app_rx_msg_if_ctrl

Control FSM for the echo app's receive message interface. Pops an active flow ID, fetches the 1-flit app header from the TCP RX buffer, requests the payload and hands it to the TX interface. After the echo completes it advances the RX head pointer, then requeues the flow unless the header's `last` flag is set. It drives the store/mux controls of `echo_app_rx_msg_if_datap` and owns every valid/ready handshake around it.

## Interface
- No parameters; coordinates and field widths come from the datapath and shared package.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `active_q_msg_if_empty`  in  1  active flow queue empty
- `msg_if_active_q_rd_req`  out  1  pop active queue; data valid same cycle
- `active_q_msg_if_full`  in  1  active flow queue full
- `msg_if_active_q_wr_req`  out  1  push stored flowid
- `rx_app_noc_vrtoc_val` / `noc_vrtoc_rx_app_rdy`  out/in  1  NoC request-flit handshake
- `noc_ctovr_rx_app_val` / `rx_app_noc_ctovr_rdy`  in/out  1  NoC notification-flit handshake
- `datap_rd_buf_req_val` / `rd_buf_datap_req_rdy`  out/in  1  buffer read request
- `rd_buf_datap_resp_data_val` / `datap_rd_buf_resp_data_rdy`  in/out  1  buffer read response beats
- `rd_buf_datap_resp_data_last`  in  1  final response beat
- `rx_if_tx_if_msg_val` / `tx_if_rx_if_msg_rdy`  out/in  1  message handoff to TX interface
- `tx_if_rx_if_msg_done`  in  1  pulse: TX finished reading payload
- `ctrl_datap_store_flowid`, `ctrl_datap_store_hdr`, `ctrl_datap_store_notif`  out  1  datapath register enables
- `ctrl_datap_buf_mux_sel`  out  `buf_mux_sel_e`  `HDR_VALUES` / `PAYLOAD_VALUES` / `PTR_UPDATE`
- `datap_ctrl_last_req`  in  1  stored header's `last` flag
- `ctrl_msgs_done`  out  32  count of completed messages, wraps

## Operation
- States: `READ_ACTIVE`, `HDR_REQ`, `HDR_NOTIF`, `HDR_BUF_REQ`, `HDR_BUF_RESP`, `PL_REQ`, `PL_NOTIF`, `TX_MSG`, `TX_WAIT`, `PTR_UPD`, `REQUEUE`.
- `ctrl_datap_buf_mux_sel` defaults to `PAYLOAD_VALUES`. It is `HDR_VALUES` in `HDR_REQ`/`HDR_NOTIF`/`HDR_BUF_REQ`/`HDR_BUF_RESP` and `PTR_UPDATE` in `PTR_UPD`.
- `READ_ACTIVE`: while `!empty`, assert `rd_req` and `store_flowid` -> `HDR_REQ`.
- `HDR_REQ` / `PL_REQ` / `PTR_UPD`: assert `vrtoc_val`; on `rdy` -> `HDR_NOTIF` / `PL_NOTIF` / `REQUEUE`.
- `HDR_NOTIF` / `PL_NOTIF`: assert `ctovr_rdy`; on `val` assert `store_notif` -> `HDR_BUF_REQ` / `TX_MSG`.
- `HDR_BUF_REQ`: assert `rd_buf_req_val`; on `rdy` -> `HDR_BUF_RESP`.
- `HDR_BUF_RESP`: assert `resp_rdy`.
  - `store_hdr` on the first valid beat only (tracked by a first-beat flag).
  - On `val & last` -> `PL_REQ`.
- `TX_MSG`: assert `rx_if_tx_if_msg_val`; on `rdy` -> `TX_WAIT`.
- `TX_WAIT`: on `tx_if_rx_if_msg_done` -> `PTR_UPD`. A `done` arriving in any other state is ignored.
- `REQUEUE`:
  - If `datap_ctrl_last_req`: flow dropped; increment `ctrl_msgs_done` -> `READ_ACTIVE`.
  - Else, once `!full`: assert `wr_req` for 1 cycle; increment counter -> `READ_ACTIVE`.
- One message in flight at a time.

## Timing
- Reset: state `READ_ACTIVE`, every val/rdy/req/store output 0, `ctrl_msgs_done` 0, first-beat flag set. Mux sel is `PAYLOAD_VALUES`.
- All handshake outputs are combinational from state. Transfer occurs when val & rdy are high in the same cycle; the state advances on that edge.
- Minimum message latency with all peers ready and `done` immediate: 11 cycles, pop to next `READ_ACTIVE`.
- Valid outputs hold until accepted; no output depends combinationally on its own ready.
- Reset mid-message abandons the message: no pointer update and no requeue.

## Structure
- `buf_mux_sel_e` and the state enum live in the shared echo app package.
- No sub-module. Top-level integration instantiates this block beside `echo_app_rx_msg_if_datap`.

## Test plan
- Single flow, `last=0`, all ready: pop flowid 3, observe the 11-state walk. Mux sel is `HDR_VALUES` during the header phase, `PTR_UPDATE` for one flit, then a push of 3 and counter=1.
- `last=1`: same walk, no `wr_req`, counter increments.
- Backpressure: hold `noc_vrtoc_rx_app_rdy=0` for 5 cycles in each request state. `val` stays high, no state change, exactly one flit per phase.
- Multi-beat header response (3 beats, last on beat 3): `store_hdr` asserted on beat 1 only.
- Queue full in `REQUEUE` for 4 cycles: no `wr_req` until `full` drops, then a 1-cycle push.
- Assert `rst` during `TX_WAIT`: outputs return to reset values, and a later `done` pulse causes no transition.
